// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data width, register index width, R-type field
// positions and the bubble instruction encoding.
// Imported by decode_regread and regfile_2r1w.
package pipeline_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    // MIPS R-type register field positions
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage : pipeline_pkg

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: NREG x XLEN register file, one write port, two combinational
// read ports. Synchronous active-low clear; R0 is hardwired to zero.
// Ports: clock, reset | wr_en, wr_idx, wr_data | rd_idx1/rd_data1, rd_idx2/rd_data2
// Build option: REGREAD_WB_BYPASS_EN forwards the same-cycle write data to a
// matching read port (write-first); otherwise reads return the pre-write value.
module regfile_2r1w
    import pipeline_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  reg_idx_t      wr_idx,
    input  logic [DW-1:0] wr_data,
    input  reg_idx_t      rd_idx1,
    output logic [DW-1:0] rd_data1,
    input  reg_idx_t      rd_idx2,
    output logic [DW-1:0] rd_data2
);

    logic [DW-1:0] regs_q [NREG];

    // Index 0 is never written, so it stays at its cleared value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_idx != '0)) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    // A write to R0 never forwards, so the R0 check covers the bypass too.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (rd_idx1 != '0) begin
`ifdef REGREAD_WB_BYPASS_EN
            rd_data1 = (wr_en && (wr_idx == rd_idx1)) ? wr_data : regs_q[rd_idx1];
`else
            rd_data1 = regs_q[rd_idx1];
`endif
        end
        if (rd_idx2 != '0) begin
`ifdef REGREAD_WB_BYPASS_EN
            rd_data2 = (wr_en && (wr_idx == rd_idx2)) ? wr_data : regs_q[rd_idx2];
`else
            rd_data2 = regs_q[rd_idx2];
`endif
        end
    end

endmodule : regfile_2r1w

// File: rtl/decode_regread.sv
// decode_regread: IF/ID pipeline register, R-type field extraction and
// two-operand register read for the ID/EX stage.
// Ports: clock, reset (sync, active-low) | if_instr/if_valid, stall, flush |
//        wb_we/wb_rd/wb_data | id_instr, id_valid, data_out1, data_out2, rd
// Build option: REGREAD_WB_BYPASS_EN (write-back to decode bypass, in regfile_2r1w).
module decode_regread
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] if_instr,
    input  logic            if_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] id_instr,
    output logic            id_valid,
    output logic [XLEN-1:0] data_out1,
    output logic [XLEN-1:0] data_out2,
    output logic [4:0]      rd
);

    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic            id_valid_q, id_valid_d;
    reg_idx_t        rs_idx, rt_idx;

    // Flush wins over stall: a squashed slot must not survive a held cycle.
    always_comb begin
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (flush) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_instr_d = if_instr;
            id_valid_d = if_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else begin
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign rs_idx = id_instr_q[RS_HI:RS_LO];
    assign rt_idx = id_instr_q[RT_HI:RT_LO];

    // Register writes are independent of stall/flush so a held instruction
    // picks up write-back results on the following cycles.
    regfile_2r1w #(
        .DW   (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wb_we),
        .wr_idx   (wb_rd),
        .wr_data  (wb_data),
        .rd_idx1  (rs_idx),
        .rd_data1 (data_out1),
        .rd_idx2  (rt_idx),
        .rd_data2 (data_out2)
    );

    assign id_instr = id_instr_q;
    assign id_valid = id_valid_q;
    // A bubble targets R0 so downstream write-back becomes a no-op.
    assign rd       = id_valid_q ? id_instr_q[RD_HI:RD_LO] : 5'd0;

endmodule : decode_regread
